// File: rtl/logic_op_arbiter_pkg.sv
// Shared definitions for the logic-op arbiter: opcode values, opcode width
// and the sequencer state encoding.
package logic_op_arbiter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_arbiter_logic_unit.sv
// Purely combinational bitwise logic unit shared by all requesters.
module logic_unit
    import logic_op_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    // opcode decode; NOR matches the existing gate cell form ~(a|b)
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter/sequencer: grants one requester at a time to the shared
// logic unit and returns the tagged result over a valid/ready response port.
module logic_op_arbiter
    import logic_op_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]  req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data
);

    state_t            state_r, state_next_s;
    logic [ID_W-1:0]   ptr_r;
    logic [WIDTH-1:0]  a_r, b_r;
    logic [OP_W-1:0]   op_r;
    logic [ID_W-1:0]   id_r;
    logic [ID_W-1:0]   grant_id_s;
    logic              grant_found_s;
    logic              accept_s;
    logic [WIDTH-1:0]  unit_y_s;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [WIDTH-1:0]  rsp_data_r;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        s = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
        return ID_W'(s);
    endfunction

    // first valid requester searching upward from ptr with wrap
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_id_s    = (req_valid[wrap_idx(ptr_r, k)] && !grant_found_s) ? wrap_idx(ptr_r, k) : grant_id_s;
            grant_found_s = grant_found_s | req_valid[wrap_idx(ptr_r, k)];
        end
    end

    // grant is combinational in IDLE and suppressed while reset is high
    always_comb begin
        req_ready = '0;
        if (!rst && (state_r == S_IDLE) && grant_found_s) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_s;
        end else begin
            req_ready = '0;
        end
    end

    assign accept_s = |(req_valid & req_ready);

    // next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  state_next_s = accept_s ? S_EXEC : S_IDLE;
            S_EXEC:  state_next_s = S_RESP;
            S_RESP:  state_next_s = rsp_ready ? S_IDLE : S_RESP;
            default: state_next_s = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // operand capture and pointer rotation, only on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= '0;
            id_r  <= '0;
            ptr_r <= '0;
        end else if (accept_s) begin
            a_r   <= req_a[grant_id_s*WIDTH +: WIDTH];
            b_r   <= req_b[grant_id_s*WIDTH +: WIDTH];
            op_r  <= req_op[grant_id_s*OP_W +: OP_W];
            id_r  <= grant_id_s;
            ptr_r <= (grant_id_s == ID_W'(NUM_REQ-1)) ? '0 : grant_id_s + ID_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    logic_unit #(.WIDTH(WIDTH)) u_unit (
        .a  (a_r),
        .b  (b_r),
        .op (op_r),
        .y  (unit_y_s)
    );

    // response registers: loaded in EXEC, held in RESP until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= '0;
        end else begin
            case (state_r)
                S_EXEC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= id_r;
                    rsp_data_r  <= unit_y_s;
                end
                S_RESP: begin
                    rsp_valid_r <= rsp_ready ? 1'b0 : 1'b1;
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed vector table, corner
// sequences and a randomized run against a truth-table reference model.
module tb_logic_op_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a, req_b;
    logic [N*3-1:0]  req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_data;

    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    logic [2:0]   rop [N];

    int n_cmp = 0;
    int n_bad = 0;

    // truth table per opcode, indexed by {a_bit, b_bit}
    localparam logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                                      4'b0110, 4'b1001, 4'b0011, 4'b1100};

    typedef struct {
        string      nm;
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [9];

    logic_op_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [3:0] tt;
        logic [7:0] r;
        tt = TT[op];
        for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic logic [3:0] first_from(input logic [3:0] v, input int p);
        logic [3:0] one;
        one = 4'b0001;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return one << ((p + k) % N);
        end
        return 4'b0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = ra[i];
            req_b[i*W +: W] = rb[i];
            req_op[i*3 +: 3] = rop[i];
        end
    endtask

    // one isolated transaction with rsp_ready held high
    task automatic do_op(input vec_t v);
        int w;
        logic [3:0] one;
        one = 4'b0001;
        ra[v.id] = v.a; rb[v.id] = v.b; rop[v.id] = v.op;
        pack();
        req_valid = one << v.id;
        rsp_ready = 1'b1;
        #1;
        w = 0;
        while (req_ready !== (one << v.id) && w < 20) begin
            tick();
            w++;
        end
        chk({v.nm, "_grant"}, 32'(req_ready), 32'(one << v.id));
        tick();
        req_valid = '0;
        chk({v.nm, "_exec_novalid"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({v.nm, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({v.nm, "_rsp_id"}, 32'(rsp_id), 32'(v.id));
        chk({v.nm, "_rsp_data"}, 32'(rsp_data), 32'(v.exp));
        tick();
        chk({v.nm, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin : main
        logic [3:0] exp_ready;
        logic [3:0] one;
        int mptr, since, last_acc, eid;
        logic busy;
        logic [7:0] edata;
        one = 4'b0001;

        for (int i = 0; i < N; i++) begin
            ra[i]  = 8'(8'h13 * (i + 1));
            rb[i]  = 8'(8'hC3 ^ i);
            rop[i] = 3'((2 * i + 1) % 8);
        end
        pack();
        rst = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;

        // reset held with every requester valid
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);

        // round robin with all valid
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_exec", 32'(rsp_valid), 32'd0);
            tick();
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(k % N));
            chk("rr_data", 32'(rsp_data), 32'(ref_op(ra[k % N], rb[k % N], rop[k % N])));
            tick();
            chk("rr_next_grant", 32'(req_ready), 32'(one << ((k + 1) % N)));
        end
        req_valid = '0;
        #1;

        // backpressure on requester 3 (ptr is 2)
        ra[3] = 8'h5C; rb[3] = 8'h3A; rop[3] = 3'd4;
        pack();
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'hF;
        #1;
        chk("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd3);
            chk("bp_data", 32'(rsp_data), 32'h66);
            chk("bp_ready_low", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_single", 32'(rsp_valid), 32'd0);
        chk("bp_after_grant", 32'(req_ready), 32'h1);
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;

        // directed vector table
        vecs[0] = '{"nor_r2", 2, 8'hF0, 8'h0C, 3'd3, 8'h03};
        vecs[1] = '{"sw_and", 0, 8'hA5, 8'h3C, 3'd0, 8'h24};
        vecs[2] = '{"sw_or",  0, 8'hA5, 8'h3C, 3'd1, 8'hBD};
        vecs[3] = '{"sw_nand",0, 8'hA5, 8'h3C, 3'd2, 8'hDB};
        vecs[4] = '{"sw_nor", 0, 8'hA5, 8'h3C, 3'd3, 8'h42};
        vecs[5] = '{"sw_xor", 0, 8'hA5, 8'h3C, 3'd4, 8'h99};
        vecs[6] = '{"sw_xnor",0, 8'hA5, 8'h3C, 3'd5, 8'h66};
        vecs[7] = '{"sw_not", 0, 8'hA5, 8'h3C, 3'd6, 8'h5A};
        vecs[8] = '{"sw_pass",0, 8'hA5, 8'h3C, 3'd7, 8'hA5};
        for (int v = 0; v < 9; v++) do_op(vecs[v]);

        // reset during EXEC: result discarded, pointer back to 0
        ra[2] = 8'hFF; rb[2] = 8'h00; rop[2] = 3'd1;
        pack();
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        chk("mr_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        chk("mr_no_valid", 32'(rsp_valid), 32'd0);
        chk("mr_data", 32'(rsp_data), 32'd0);
        chk("mr_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("mr_lowest", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("mr_exec", 32'(rsp_valid), 32'd0);
        tick();
        chk("mr_rsp_id", 32'(rsp_id), 32'd1);
        chk("mr_rsp_data", 32'(rsp_data), 32'(ref_op(ra[1], rb[1], rop[1])));
        tick();

        // randomized traffic against the reference model
        mptr = 2; busy = 1'b0; since = 0; last_acc = -1; eid = 0; edata = '0;
        for (int c = 0; c < 500; c++) begin
            if (last_acc >= 0) req_valid[last_acc] = 1'b0;
            last_acc = -1;
            if (busy) since++;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    ra[i]  = 8'($urandom);
                    rb[i]  = 8'($urandom);
                    rop[i] = 3'($urandom_range(0, 7));
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                end
            end
            pack();
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            exp_ready = busy ? 4'b0000 : first_from(req_valid, mptr);
            chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(busy && since >= 2));
            if (busy && since >= 2) begin
                chk("rnd_rsp_id", 32'(rsp_id), 32'(eid));
                chk("rnd_rsp_data", 32'(rsp_data), 32'(edata));
                if (rsp_ready) busy = 1'b0;
            end
            if (exp_ready != 4'b0000) begin
                for (int i = 0; i < N; i++) begin
                    if (exp_ready[i]) begin
                        eid = i;
                        edata = ref_op(ra[i], rb[i], rop[i]);
                        mptr = (i + 1) % N;
                        last_acc = i;
                    end
                end
                busy = 1'b1;
                since = 0;
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
